muldiv_seq: RTL and testbench

Multi-cycle sequencer and datapath for the RV32M operations that the decoder flags on alu_op[18:12]: mul, mulh, mulhu, div, divu, rem and remu. The execute stage launches an operation with a start pulse and stalls on busy. The block returns a 32-bit result with a one-cycle done pulse. Multiply uses iterative shift-add and divide uses restoring division, one bit per cycle, so no single-cycle 32x32 multiplier or divider is needed in the ALU.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv_seq.sv | 129 ++++++++++++
 tb/tb_muldiv_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit:
// op bit positions, FSM encoding and the architectural corner-case constants.
package muldiv_pkg;

  localparam int MD_XLEN = 32;

  localparam int OP_MUL   = 0;
  localparam int OP_MULH  = 1;
  localparam int OP_MULHU = 2;
  localparam int OP_DIV   = 3;
  localparam int OP_DIVU  = 4;
  localparam int OP_REM   = 5;
  localparam int OP_REMU  = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [MD_XLEN-1:0] DIV_BY_ZERO_Q = '1;
  localparam logic [MD_XLEN-1:0] INT_MIN       = {1'b1, {(MD_XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring
// shift-subtract for divide. Purely combinational.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    // Remainder after the left shift can reach 2*divisor-1, so keep one extra bit.
    rem_sh = acc[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, opnd};
    if (is_div) begin
      if (!diff[XLEN]) begin
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: operates on magnitudes one bit per cycle, then
// applies sign correction. Divide-by-zero and signed overflow bypass the loop.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [6:0]      op,
  input  logic [XLEN-1:0] src0,
  input  logic [XLEN-1:0] src1,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  state_t            state, state_nxt;
  logic [6:0]        op_q;
  logic              s0_q, s1_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q, acc_nxt;
  logic [CW-1:0]     cnt_q;

  logic [6:0]        op_sel;
  logic              is_mul, is_signed, s0, s1, launch, fast;
  logic [XLEN-1:0]   abs0, abs1, fast_res, fix_res, quo, rem;
  logic [2*XLEN-1:0] prod;

  // Multi-hot op vectors resolve to their lowest set bit.
  always_comb begin
    op_sel    = op & (~op + 7'd1);
    is_mul    = op_sel[OP_MUL] | op_sel[OP_MULH] | op_sel[OP_MULHU];
    is_signed = op_sel[OP_MUL] | op_sel[OP_MULH] | op_sel[OP_DIV] | op_sel[OP_REM];
    s0        = is_signed & src0[XLEN-1];
    s1        = is_signed & src1[XLEN-1];
    abs0      = s0 ? -src0 : src0;
    abs1      = s1 ? -src1 : src1;
    launch    = start && (op != 7'd0) && !flush;
    fast      = !is_mul && ((src1 == '0) ||
                ((op_sel[OP_DIV] | op_sel[OP_REM]) && src0 == INT_MIN && src1 == DIV_BY_ZERO_Q));
    if (src1 == '0) begin
      fast_res = (op_sel[OP_DIV] | op_sel[OP_DIVU]) ? DIV_BY_ZERO_Q : src0;
    end else begin
      fast_res = op_sel[OP_DIV] ? INT_MIN : '0;
    end
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (!(op_q[OP_MUL] | op_q[OP_MULH] | op_q[OP_MULHU])),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_nxt)
  );

  always_comb begin
    prod = (s0_q ^ s1_q) ? -acc_q : acc_q;
    quo  = (s0_q ^ s1_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = s0_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[OP_MUL]) begin
      fix_res = prod[XLEN-1:0];
    end else if (op_q[OP_MULH] | op_q[OP_MULHU]) begin
      fix_res = prod[2*XLEN-1:XLEN];
    end else if (op_q[OP_DIV] | op_q[OP_DIVU]) begin
      fix_res = quo;
    end else begin
      fix_res = rem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (launch) state_nxt = fast ? S_DONE : S_CALC;
        S_CALC:  if (cnt_q == '0) state_nxt = S_FIX;
        S_FIX:   state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: if (launch) begin
          op_q  <= op_sel;
          s0_q  <= s0;
          s1_q  <= s1;
          cnt_q <= CW'(XLEN - 1);
          // Multiplier / dividend sit in the low half so both loops shift the same register.
          acc_q  <= {{XLEN{1'b0}}, is_mul ? abs1 : abs0};
          opnd_q <= is_mul ? abs0 : abs1;
          if (fast) result <= fast_res;
        end
        S_CALC: begin
          acc_q <= acc_nxt;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        S_FIX: if (!flush) result <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE) && !flush;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and random checks of muldiv_seq against a plain-arithmetic RV32M model,
// including latency, fast paths, flush, reset and ignored starts.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [6:0]  op;
  logic [31:0] src0, src1;
  logic        busy, done;
  logic [31:0] result;

  int compared   = 0;
  int mismatched = 0;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src0(src0), .src1(src1),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input int k, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned up;
    logic [63:0]     w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (k)
      0: begin sp = sa * sb; w = sp; return w[31:0]; end
      1: begin sp = sa * sb; w = sp; return w[63:32]; end
      2: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); w = up; return w[63:32]; end
      3: begin if (b == 0) return 32'hFFFF_FFFF; sp = sa / sb; w = sp; return w[31:0]; end
      4: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      5: begin if (b == 0) return a; sp = sa % sb; w = sp; return w[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int latency(input int k, input logic [31:0] a, input logic [31:0] b);
    if (k >= 3 && (b == 0 || ((k == 3 || k == 5) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 34;
  endfunction

  // Start is sampled at the next edge (edge 0); returns in cycle 1, #1 after that edge.
  task automatic launch(input logic [6:0] opv, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = opv; src0 = a; src1 = b;
    @(posedge clk); #1;
    start = 1'b0; op = 7'($urandom); src0 = $urandom; src1 = $urandom;
  endtask

  task automatic wait_check(input int cyc0, input int k, input logic [31:0] a,
                            input logic [31:0] b, input string tag);
    int cyc;
    cyc = cyc0;
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " done cycle"}, cyc, latency(k, a, b));
    chk({tag, " result"}, result, model(k, a, b));
    chk({tag, " busy at done"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk({tag, " busy after"}, {31'd0, busy}, 32'd0);
    chk({tag, " done after"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input string tag);
    launch(7'(1 << k), a, b);
    wait_check(1, k, a, b, tag);
  endtask

  initial begin
    logic [31:0] prior, a, b;
    int          k;
    bit          saw;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src0 = '0; src1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;

    run_op(0, 32'd7, 32'hFFFF_FFFD, "mul 7*-3");
    run_op(1, 32'h8000_0000, 32'h8000_0000, "mulh min*min");
    run_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu max*max");
    run_op(3, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    run_op(5, 32'hFFFF_FFF9, 32'd2, "rem -7/2");
    run_op(4, 32'hFFFF_FFF9, 32'd2, "divu");
    run_op(4, 32'd5, 32'd0, "divu by zero");
    run_op(6, 32'd5, 32'd0, "remu by zero");
    run_op(3, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
    run_op(5, 32'h8000_0000, 32'hFFFF_FFFF, "rem overflow");
    run_op(6, 32'd100, 32'd7, "remu 100/7");

    // Multi-hot op: lowest bit (mulh) wins.
    launch(7'b0101010, 32'h1234_5678, 32'hFEDC_BA98);
    wait_check(1, 1, 32'h1234_5678, 32'hFEDC_BA98, "multi-hot op");

    // Start with op==0 does not launch.
    @(negedge clk); start = 1'b1; op = 7'd0; src0 = 32'd3; src1 = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    chk("op zero ignored", {31'd0, busy}, 32'd0);

    // Start pulse in cycle 5 of a running div is ignored.
    launch(7'b0001000, 32'd100, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; op = 7'b0000001; src0 = 32'd3; src1 = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    wait_check(6, 3, 32'd100, 32'd7, "start while busy");

    // Flush during CALC: no done, result held.
    prior = model(3, 32'd100, 32'd7);
    launch(7'b0000001, 32'd5, 32'd6);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    saw = 1'b0;
    repeat (40) begin
      if (done) saw = 1'b1;
      @(posedge clk); #1;
    end
    chk("flush no done", {31'd0, saw}, 32'd0);
    chk("flush result held", result, prior);

    // Flush together with start in IDLE: no launch.
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 7'b0010000; src0 = 32'd9; src1 = 32'd3;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    chk("flush+start", {31'd0, busy}, 32'd0);

    // Reset mid-operation.
    launch(7'b0010000, 32'd1000, 32'd3);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst result", result, 32'd0);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 6);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(k, a, b, $sformatf("rand%0d op%0d", i, k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
